fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the RISC-V pipeline. It owns the program counter and issues one-outstanding requests to the instruction memory over a req/ack handshake with wait states. It loads the IF/ID register and honours ID-stage stalls. It applies branch/jump redirects from EX (PCSrc), including flushing IF/ID and discarding any memory response that is already in flight.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/fetch_ctrl.sv | 134 +++++++++++++
 tb/tb_fetch_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared types and constants for the RISC-V pipeline blocks.
//               XLEN            - architectural register / address width
//               INST_BYTES      - size of one instruction word in bytes
//               fetch_state_e   - instruction-fetch sequencer states
//               RESET_PC_DEFAULT- default program counter after reset
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int INST_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,    // single idle cycle after reset release
        RUN  = 2'd1,    // normal fetch
        KILL = 2'd2     // redirected request still outstanding at memory
    } fetch_state_e;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch sequencer. Owns the PC, issues one
//               outstanding request at a time to instruction memory over a
//               req/ack handshake, loads the IF/ID register, honours ID
//               stalls and applies EX redirects (flushing IF/ID and
//               discarding any response already in flight).
// Ports       : clk            - pipeline clock, rising edge
//               res_n          - asynchronous active-low reset
//               imem_req/addr  - request and word byte address to memory
//               imem_ack/rdata - completion and instruction word from memory
//               redirect_valid - EX redirect request
//               redirect_pc    - redirect target (bits [1:0] ignored)
//               id_stall       - ID cannot accept IF/ID this cycle
//               if_id_valid/inst/pc - registered IF/ID contents
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            res_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_stall,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_inst,
    output logic [XLEN-1:0] if_id_pc
);

    localparam logic [XLEN-1:0] c_align_mask = XLEN'(INST_BYTES - 1);
    localparam logic [XLEN-1:0] c_pc_step    = XLEN'(INST_BYTES);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_kill_addr;
    logic            r_pending;     // request raised earlier, not yet acked
    logic            r_if_id_valid;
    logic [XLEN-1:0] r_if_id_inst;
    logic [XLEN-1:0] r_if_id_pc;

    logic            w_slot_free;
    logic            w_req;
    logic [XLEN-1:0] w_redirect_target;

    assign w_slot_free       = !r_if_id_valid || !id_stall;
    assign w_redirect_target = redirect_pc & ~c_align_mask;

    // A pending request is never withdrawn, even if ID stalls meanwhile.
    // While a request is pending IF/ID is always empty, so an ack can
    // never overwrite a held instruction.
    always_comb begin
        w_req = 1'b0;
        case (r_state)
            RUN:     w_req = w_slot_free || r_pending;
            KILL:    w_req = 1'b1;
            default: w_req = 1'b0;
        endcase
    end

    assign imem_req    = w_req;
    assign imem_addr   = (r_state == KILL) ? r_kill_addr : r_pc;
    assign if_id_valid = r_if_id_valid;
    assign if_id_inst  = r_if_id_inst;
    assign if_id_pc    = r_if_id_pc;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_kill_addr   <= RESET_PC;
            r_pending     <= 1'b0;
            r_if_id_valid <= 1'b0;
            r_if_id_inst  <= '0;
            r_if_id_pc    <= '0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state <= RUN;
                end

                RUN: begin
                    if (redirect_valid) begin
                        // Flush wins over id_stall; a coincident ack is dropped.
                        r_pc          <= w_redirect_target;
                        r_if_id_valid <= 1'b0;
                        r_pending     <= 1'b0;
                        if (w_req && !imem_ack) begin
                            // Memory still owes a response for the old address;
                            // keep presenting it until it completes.
                            r_kill_addr <= r_pc;
                            r_state     <= KILL;
                        end
                    end else if (w_req && imem_ack) begin
                        r_if_id_inst  <= imem_rdata;
                        r_if_id_pc    <= r_pc;
                        r_if_id_valid <= 1'b1;
                        r_pc          <= r_pc + c_pc_step;
                        r_pending     <= 1'b0;
                    end else begin
                        r_pending <= w_req;
                        if (r_if_id_valid && !id_stall) begin
                            r_if_id_valid <= 1'b0;
                        end
                    end
                end

                KILL: begin
                    if (redirect_valid) begin
                        r_pc          <= w_redirect_target;
                        r_if_id_valid <= 1'b0;
                    end
                    // Response for the killed address is discarded.
                    if (imem_ack) begin
                        r_state <= RUN;
                    end
                end

                default: begin
                    r_state <= BOOT;
                end
            endcase
        end
    end

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking directed bench for fetch_ctrl. The memory
//               returns the request address as instruction data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic        clk;
    logic        res_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        if_id_valid;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;

    int n_cmp;
    int n_bad;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .res_n          (res_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .if_id_valid    (if_id_valid),
        .if_id_inst     (if_id_inst),
        .if_id_pc       (if_id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus: inputs change on the falling edge, the memory
    // answers with the address as data, and outputs are settled on return.
    task automatic drive(input logic ack, input logic stall,
                         input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        id_stall       = stall;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_ack       = ack;
        #1;
        imem_rdata     = imem_addr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        res_n          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_stall       = 1'b0;
        @(negedge clk);
        res_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_bad++; $display("FAIL boot_req actual=%0h required=0", imem_req);
        end
        n_cmp++;
        if (imem_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_inst !== 32'h0 || if_id_pc !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_vals actual addr=%0h v=%0h inst=%0h pc=%0h required all 0",
                     imem_addr, if_id_valid, if_id_inst, if_id_pc);
        end
    endtask

    task automatic test_zero_wait();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(k < 4, 1'b0, 1'b0, 32'h0);
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
                n_bad++;
                $display("FAIL zw_req[%0d] actual req=%0h addr=%0h required req=1 addr=%0h",
                         k, imem_req, imem_addr, 4 * k);
            end
            n_cmp++;
            if (k == 0) begin
                if (if_id_valid !== 1'b0) begin
                    n_bad++; $display("FAIL zw_valid0 actual=%0h required=0", if_id_valid);
                end
            end else if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4 * (k - 1)) ||
                         if_id_inst !== 32'(4 * (k - 1))) begin
                n_bad++;
                $display("FAIL zw_ifid[%0d] actual v=%0h pc=%0h inst=%0h required v=1 pc=inst=%0h",
                         k, if_id_valid, if_id_pc, if_id_inst, 4 * (k - 1));
            end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0);            // fetch 0x0
        for (int w = 0; w < 3; w++) begin
            drive(w == 2, 1'b0, 1'b0, 32'h0);       // 0x4 with two wait states
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
                n_bad++;
                $display("FAIL ws_hold[%0d] actual req=%0h addr=%0h required req=1 addr=4",
                         w, imem_req, imem_addr);
            end
        end
        n_cmp++;
        if (if_id_valid !== 1'b0) begin
            n_bad++; $display("FAIL ws_no_dup actual v=%0h required 0", if_id_valid);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h4 || if_id_inst !== 32'h4 || imem_addr !== 32'h8) begin
            n_bad++;
            $display("FAIL ws_load actual v=%0h pc=%0h inst=%0h addr=%0h required 1/4/4/8",
                     if_id_valid, if_id_pc, if_id_inst, imem_addr);
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0);            // 0x0
        drive(1'b1, 1'b0, 1'b0, 32'h0);            // 0x4
        drive(1'b1, 1'b0, 1'b0, 32'h0);            // 0x8
        for (int s = 0; s < 3; s++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            n_cmp++;
            if (imem_req !== 1'b0 || if_id_valid !== 1'b1 || if_id_pc !== 32'h8 || if_id_inst !== 32'h8) begin
                n_bad++;
                $display("FAIL stall[%0d] actual req=%0h v=%0h pc=%0h inst=%0h required 0/1/8/8",
                         s, imem_req, if_id_valid, if_id_pc, if_id_inst);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            n_bad++;
            $display("FAIL stall_release actual req=%0h addr=%0h required 1/c", imem_req, imem_addr);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (if_id_pc !== 32'hC || if_id_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_next actual pc=%0h v=%0h required c/1", if_id_pc, if_id_valid);
        end
    endtask

    task automatic test_redirect_pending();
        do_reset();
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 1'b0, 32'h0); // 0x0..0xC
        drive(1'b0, 1'b0, 1'b0, 32'h0);             // 0x10 issued, no ack
        drive(1'b0, 1'b0, 1'b1, 32'h100);           // redirect while pending
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            n_bad++;
            $display("FAIL rp_pending actual req=%0h addr=%0h required 1/10", imem_req, imem_addr);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10 || if_id_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rp_kill actual req=%0h addr=%0h v=%0h required 1/10/0",
                     imem_req, imem_addr, if_id_valid);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);             // kill ack, data 0x10
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (imem_addr !== 32'h100 || imem_req !== 1'b1 || if_id_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rp_target actual addr=%0h req=%0h v=%0h required 100/1/0",
                     imem_addr, imem_req, if_id_valid);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100 || if_id_inst !== 32'h100) begin
            n_bad++;
            $display("FAIL rp_load actual v=%0h pc=%0h inst=%0h required 1/100/100",
                     if_id_valid, if_id_pc, if_id_inst);
        end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0);             // 0x0
        drive(1'b0, 1'b0, 1'b0, 32'h0);             // 0x4 pending
        drive(1'b1, 1'b1, 1'b1, 32'h203);           // ack + redirect + stall
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_bad++;
            $display("FAIL ra_drop actual v=%0h req=%0h addr=%0h required 0/1/200",
                     if_id_valid, imem_req, imem_addr);
        end
        drive(1'b0, 1'b1, 1'b1, 32'h300);           // stalled valid entry, redirect
        n_cmp++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h200 || imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL ra_held actual v=%0h pc=%0h req=%0h required 1/200/0",
                     if_id_valid, if_id_pc, imem_req);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        n_cmp++;
        if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            n_bad++;
            $display("FAIL ra_flush_stall actual v=%0h req=%0h addr=%0h required 0/1/300",
                     if_id_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap_and_async_reset();
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);     // ack dropped, pc -> FFFFFFFC
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (imem_addr !== 32'hFFFF_FFFC || if_id_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_top actual addr=%0h v=%0h required fffffffc/0", imem_addr, if_id_valid);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (imem_addr !== 32'h0 || if_id_pc !== 32'hFFFF_FFFC || if_id_inst !== 32'hFFFF_FFFC) begin
            n_bad++;
            $display("FAIL wrap_zero actual addr=%0h pc=%0h inst=%0h required 0/fffffffc/fffffffc",
                     imem_addr, if_id_pc, if_id_inst);
        end
        #2;
        res_n = 1'b0;                               // mid-wait, between edges
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || if_id_inst !== 32'h0 ||
            if_id_pc !== 32'h0 || imem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL async_reset actual req=%0h v=%0h inst=%0h pc=%0h addr=%0h required all 0",
                     imem_req, if_id_valid, if_id_inst, if_id_pc, imem_addr);
        end
        @(negedge clk);
        imem_ack = 1'b0;
        res_n    = 1'b1;
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        res_n          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_stall       = 1'b0;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || if_id_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL power_on actual req=%0h v=%0h required 0/0", imem_req, if_id_valid);
        end
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_redirect_pending();
        test_redirect_ack();
        test_wrap_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fetch_ctrl
`default_nettype wire
